arena_vga_renderer: RTL
=======================

Name: arena_vga_renderer

Overview:
- Read side of the arena/bomb map that the movement and bomb-timer logic write.
- Generates 640x480@60 VGA timing and scans the 10x10 arena map through a synchronous read port, one map word per tile.
- Converts each tile's arena code and bomb state into 8-bit RGB332 pixels with hsync/vsync.
- Sits between the map storage and the board VGA connector; also emits a frame tick for game-logic pacing.

Parameters:
- TILE_PX, 40, tile edge in pixels; arena is 10*TILE_PX square.
- ARENA_X0, 120, first visible column of the arena.
- ARENA_Y0, 40, first visible line of the arena.
- BORDER_RGB, 8'h02, colour of visible pixels outside the arena.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel-rate enable, one clk wide, at least 2 clk apart (25 MHz).
- map_addr  out  7  tile index row*10+col, 0..99.
- map_arena  in  2  arena code at map_addr; valid 1 clk after map_addr changes.
- map_bomb  in  2  bomb fuse state at map_addr; same timing as map_arena.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- vga_rgb  out  8  {R[2:0],G[2:0],B[1:0]}.
- frame_tick  out  1  one-clk pulse when v_cnt enters line 480.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). All state advances only on clk cycles with pix_en=1, except frame_tick width.
- Reset values: h_cnt=0, v_cnt=0, map_addr=0, hsync=1, vsync=1, vga_rgb=0, frame_tick=0, all pipeline registers cleared with blank=1.
- Reset mid-frame: everything returns to reset values immediately; the first pixel after release is (0,0).
- h_cnt 0..799 wraps to 0. v_cnt increments when h_cnt wraps; range 0..524, wraps to 0.
- Visible region: h<640 && v<480.
- Sync pulses: hsync low for h 656..751. vsync low for v 490..491.
- Tile tracking uses counters, not a divider.
  - sub_x 0..TILE_PX-1 and tile_col 0..9 reset at h=ARENA_X0 and advance per pixel inside the arena.
  - sub_y and tile_row advance at each line end while v is inside the arena, and reset at v=ARENA_Y0.
- In-arena condition: ARENA_X0<=h<ARENA_X0+400 && ARENA_Y0<=v<ARENA_Y0+400.
- Pipeline (3 stages, advancing on pix_en):
  - S0: counters. map_addr is registered as tile_row*10+tile_col when in-arena, else 0.
  - S1: captures map data plus delayed sub_x, sub_y, in_arena, blank and sync.
  - S2: registers vga_rgb, hsync and vsync.
  - Latency: outputs for pixel (h,v) appear 2 pix_en ticks after S0 held (h,v). Sync is delayed identically, so the relative timing is exact.
- Colour priority, highest first:
  - blank -> 8'h00.
  - outside arena -> BORDER_RGB.
  - map_bomb!=0 and 10<=sub_x,sub_y<30 -> fuse colour: 3=8'hE0, 2=8'hA0, 1=8'h60.
  - arena code: 0 floor=8'h10, 1 wall=8'h92, 2 brick=8'hA8, 3 player=8'hFC.
- frame_tick: asserted for exactly the clk cycle after the pix_en on which v_cnt becomes 480.
- Boundary cases:
  - map_addr=99 at the last arena tile; it never exceeds 99.
  - A map value changing mid-tile is shown from the next pixel read; no tearing protection.

Optional Feature:
- GRID_LINES_EN defined: inside the arena, pixels with sub_x==0 or sub_y==0 are 8'h00. These grid lines override bombs and arena colour.
- GRID_LINES_EN undefined: no grid; tiles are solid as above. Timing and latency are identical either way.

Test Plan:
- Reset: hold rst_n=0 mid-frame, release -> hsync=1, vsync=1, vga_rgb=0, map_addr=0. The first output pixel corresponds to (0,0) after 2 pix_en.
- Timing: run 2 frames -> 800 pix_en per line, hsync low exactly 96 pix_en, vsync low exactly 2 lines, 525 lines per frame. frame_tick pulses once per frame, 1 clk wide.
- Addressing: model map returning addr-dependent data -> map_addr=0 at (120,40), 9 at (480,40), 10 at (120,80), 99 at (480,400); 0 outside the arena.
- Colours: all tiles arena=1, bomb=0 -> arena pixels 8'h92. (100,100) gives BORDER_RGB; (700,100) gives 8'h00.
- Bomb overlay: tile 0 has arena=0, bomb=3 -> pixel (135,55)=8'hE0, pixel (125,45)=8'h10. Set bomb=1 -> (135,55)=8'h60.
- Grid macro: build with GRID_LINES_EN -> (120,60) and (140,40) are 8'h00. Build without -> the same pixels show the arena colour.

Source files
------------

// File: rtl/arena_vga_renderer.sv
// arena_vga_renderer: 640x480@60 VGA scan of a 10x10 tile map into RGB332 pixels with syncs and a frame tick.
// Define GRID_LINES_EN to draw black lines on each tile's first column and first row inside the arena.
module arena_vga_renderer #(
  parameter int         TILE_PX    = 40,
  parameter int         ARENA_X0   = 120,
  parameter int         ARENA_Y0   = 40,
  parameter logic [7:0] BORDER_RGB = 8'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [6:0] map_addr,
  input  logic [1:0] map_arena,
  input  logic [1:0] map_bomb,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] vga_rgb,
  output logic       frame_tick
);
  localparam logic [9:0] AX0 = 10'(ARENA_X0);
  localparam logic [9:0] AX1 = 10'(ARENA_X0 + 10 * TILE_PX);
  localparam logic [9:0] AY0 = 10'(ARENA_Y0);
  localparam logic [9:0] AY1 = 10'(ARENA_Y0 + 10 * TILE_PX);
  localparam logic [5:0] TMAX = 6'(TILE_PX - 1);
  localparam logic [5:0] B_LO = 6'(TILE_PX / 4);
  localparam logic [5:0] B_HI = 6'(3 * TILE_PX / 4);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [5:0] sx_q, sx_d, sy_q, sy_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic       in0_q, in_d, h_wrap, h_adv, v_adv;
  logic [6:0] addr_d;
  logic [1:0] ar1_q, bm1_q;
  logic [5:0] sx1_q, sy1_q;
  logic       in1_q, bl1_q, hs1_q, vs1_q;
  logic [7:0] rgb_d, fuse_rgb, tile_rgb;
  logic       bomb_hit, grid;

  // S0 next state: everything is computed for the pixel the counters move to, so map_addr lines up with h_q/v_q
  always_comb begin
    h_wrap = h_q == 10'd799;
    h_d    = h_wrap ? '0 : h_q + 10'd1;
    v_d    = !h_wrap ? v_q : v_q == 10'd524 ? '0 : v_q + 10'd1;
    h_adv  = h_d > AX0 && h_d < AX1;
    v_adv  = h_wrap && v_d > AY0 && v_d < AY1;
    sx_d   = h_d == AX0 ? '0 : !h_adv ? sx_q : sx_q == TMAX ? '0 : sx_q + 6'd1;
    col_d  = h_d == AX0 ? '0 : h_adv && sx_q == TMAX ? col_q + 4'd1 : col_q;
    sy_d   = v_d == AY0 ? '0 : !v_adv ? sy_q : sy_q == TMAX ? '0 : sy_q + 6'd1;
    row_d  = v_d == AY0 ? '0 : v_adv && sy_q == TMAX ? row_q + 4'd1 : row_q;
    in_d   = h_d >= AX0 && h_d < AX1 && v_d >= AY0 && v_d < AY1;
    addr_d = in_d ? 7'(row_d) * 7'd10 + 7'(col_d) : '0;
  end

  always_comb begin
    fuse_rgb = bm1_q == 2'd3 ? 8'hE0 : bm1_q == 2'd2 ? 8'hA0 : 8'h60;
    tile_rgb = ar1_q == 2'd0 ? 8'h10 : ar1_q == 2'd1 ? 8'h92 : ar1_q == 2'd2 ? 8'hA8 : 8'hFC;
    bomb_hit = bm1_q != 2'd0 && sx1_q >= B_LO && sx1_q < B_HI && sy1_q >= B_LO && sy1_q < B_HI;
`ifdef GRID_LINES_EN
    grid     = sx1_q == 6'd0 || sy1_q == 6'd0;
`else
    grid     = 1'b0;
`endif
    rgb_d    = bl1_q ? 8'h00 : !in1_q ? BORDER_RGB : grid ? 8'h00 : bomb_hit ? fuse_rgb : tile_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      v_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      in0_q      <= 1'b0;
      map_addr   <= '0;
      ar1_q      <= '0;
      bm1_q      <= '0;
      sx1_q      <= '0;
      sy1_q      <= '0;
      in1_q      <= 1'b0;
      bl1_q      <= 1'b1;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      vga_rgb    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_wrap && v_q == 10'd479;
      if (pix_en) begin
        h_q      <= h_d;
        v_q      <= v_d;
        sx_q     <= sx_d;
        sy_q     <= sy_d;
        col_q    <= col_d;
        row_q    <= row_d;
        in0_q    <= in_d;
        map_addr <= addr_d;
        ar1_q    <= map_arena;
        bm1_q    <= map_bomb;
        sx1_q    <= sx_q;
        sy1_q    <= sy_q;
        in1_q    <= in0_q;
        bl1_q    <= !(h_q < 10'd640 && v_q < 10'd480);
        hs1_q    <= !(h_q >= 10'd656 && h_q < 10'd752);
        vs1_q    <= !(v_q >= 10'd490 && v_q < 10'd492);
        vga_rgb  <= rgb_d;
        hsync    <= hs1_q;
        vsync    <= vs1_q;
      end
    end
  end
endmodule
